pll_scan_reconfig_ctrl: RTL and testbench
=========================================

// Module: pll_scan_reconfig_ctrl
// PURPOSE
//  Consumes the PLL reconfiguration ROM stage: on trigger_read it streams the
//  ROM's serial config bits into a local buffer, waits for the ROM's delayed
//  reconfig strobe, then shifts the buffer into the PLL scan chain.
//  After the shift it pulses configupdate, waits for scandone and resets the PLL.
//  busy feeds back to the ROM stage's pll_reconf_busy input, so mode changes
//  are deferred until a reconfiguration completes.
// PARAMETERS
//  SCAN_CHAIN_LEN   144   scan-chain bits; ROM addresses 0..SCAN_CHAIN_LEN-1 (<=256)
//  ROM_LATENCY      2     clocks from rom_address/rom_read_ena to valid rom_q
//  TIMEOUT_CYCLES   1024  max wait for rom_reconfig or pll_scandone
//  PLL_RESET_CYCLES 4     width of pll_areset pulse
// PORTS
//  clock             in   1  system clock
//  reset             in   1  asynchronous, active-high reset
//  trigger_read      in   1  1-clock start request from ROM stage
//  rom_address       out  8  ROM bit address
//  rom_read_ena      out  1  ROM read enable; its falling edge arms ROM reconfig strobe
//  rom_q             in   1  ROM serial data, ROM_LATENCY after address
//  rom_reconfig      in   1  1-clock strobe from ROM, 3 clocks after read_ena falls
//  pll_scanclk       out  1  scan clock, clock/2 while shifting, else 0
//  pll_scanclkena    out  1  scan clock enable
//  pll_scandata      out  1  scan data, stable across scanclk rising edge
//  pll_configupdate  out  1  1-clock update pulse
//  pll_scandone      in   1  PLL reconfiguration complete (level)
//  pll_areset        out  1  PLL reset pulse
//  busy              out  1  high whenever FSM is not IDLE
//  error             out  1  sticky timeout flag, cleared by next accepted trigger
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, buffer 0; takes effect mid-operation.
//  - IDLE: trigger_read=1 -> LOAD next clock; busy=1 from that clock; error cleared.
//  - trigger_read while busy is ignored (no queueing).
//  - LOAD: rom_read_ena=1 for exactly SCAN_CHAIN_LEN clocks, rom_address=0,1,..
//    one per clock. A ROM_LATENCY-deep valid pipeline captures rom_q into
//    buffer[k] for address k. Exit to WAIT_RECONF when the last bit is captured
//    (SCAN_CHAIN_LEN+ROM_LATENCY clocks after entry). rom_address holds last value.
//  - WAIT_RECONF: rom_read_ena=0; on rom_reconfig=1 -> SHIFT. Timeout counter
//    reaching TIMEOUT_CYCLES -> error=1, IDLE.
//  - SHIFT: pll_scanclkena=1; pll_scanclk toggles every clock, starting low.
//    pll_scandata=buffer[k] updated on the clock scanclk goes low, bit 0 first.
//    Exactly SCAN_CHAIN_LEN rising edges; ends with scanclk=0, scanclkena=0 -> UPDATE.
//  - UPDATE: pll_configupdate=1 for exactly 1 clock -> WAIT_DONE.
//  - WAIT_DONE: pll_scandone 0->1 edge (sampled, edge after UPDATE) -> PLL_RST;
//    timeout -> error=1, IDLE (no pll_areset).
//  - PLL_RST: pll_areset=1 for PLL_RESET_CYCLES clocks -> IDLE; busy=0 in IDLE.
//  - Counters: bit counter 9 bit, saturating compare against SCAN_CHAIN_LEN-1;
//    timeout counter clog2(TIMEOUT_CYCLES+1) bits, cleared on every state entry.
//  - rom_reconfig outside WAIT_RECONF and scandone outside WAIT_DONE are ignored.
// TESTING
//  1 Reset asserted mid-SHIFT -> all outputs 0 same cycle; after release busy=0, new trigger works.
//  2 trigger, ROM model bit k=k[0]^k[3], latency 2 -> read_ena high 144 clk, addr 0..143,
//    144 scanclk rises with scandata matching pattern, 1 configupdate, areset 4 clk, busy=0.
//  3 Second trigger_read during SHIFT -> ignored; exactly one 144-bit sequence observed.
//  4 rom_reconfig never strobed -> error=1 at 1024 clk in WAIT_RECONF, busy=0, no scanclk.
//  5 scandone held 0 -> error=1 after 1024 clk, no areset; next trigger clears error.
//  6 SCAN_CHAIN_LEN=8, ROM_LATENCY=1 -> 8 addresses, 8 scan edges, capture aligned.

Source files
------------

// File: rtl/pll_scan_reconfig_ctrl.sv
// Loads PLL scan-chain bits from the reconfiguration ROM, shifts them into the
// PLL scan chain, pulses configupdate, waits for scandone and resets the PLL.
//
// state       | meaning
// IDLE        | waiting for trigger_read; busy low
// LOAD        | reading ROM addresses 0..N-1 and capturing rom_q into the buffer
// WAIT_RECONF | waiting for the ROM's delayed reconfig strobe (timeout -> error)
// SHIFT       | clocking the buffer into the scan chain, bit 0 first
// UPDATE      | one-clock pll_configupdate pulse
// WAIT_DONE   | waiting for a rising edge on pll_scandone (timeout -> error)
// PLL_RST     | holding pll_areset for PLL_RESET_CYCLES clocks
module pll_scan_reconfig_ctrl #(
  parameter int SCAN_CHAIN_LEN   = 144,
  parameter int ROM_LATENCY      = 2,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int PLL_RESET_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger_read,
  output logic [7:0] rom_address,
  output logic       rom_read_ena,
  input  logic       rom_q,
  input  logic       rom_reconfig,
  output logic       pll_scanclk,
  output logic       pll_scanclkena,
  output logic       pll_scandata,
  output logic       pll_configupdate,
  input  logic       pll_scandone,
  output logic       pll_areset,
  output logic       busy,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOAD        = 3'd1;
  localparam logic [2:0] S_WAIT_RECONF = 3'd2;
  localparam logic [2:0] S_SHIFT       = 3'd3;
  localparam logic [2:0] S_UPDATE      = 3'd4;
  localparam logic [2:0] S_WAIT_DONE   = 3'd5;
  localparam logic [2:0] S_PLL_RST     = 3'd6;

  localparam logic [8:0]    LAST_BIT  = 9'(SCAN_CHAIN_LEN - 1);
  localparam logic [7:0]    LAST_ADDR = 8'(SCAN_CHAIN_LEN - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] RST_LAST  = TW'(PLL_RESET_CYCLES - 1);

  logic [2:0]                state_q, state_d;
  logic [7:0]                addr_q, addr_d;
  logic                      rd_ena_q, rd_ena_d;
  logic [ROM_LATENCY-1:0]    vld_q, vld_d;
  logic [8:0]                bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [SCAN_CHAIN_LEN-1:0] buf_q, buf_d;
  logic                      sclk_q, sclk_d;
  logic                      sclkena_q, sclkena_d;
  logic                      sdata_q, sdata_d;
  logic                      upd_q, upd_d;
  logic                      areset_q, areset_d;
  logic                      error_q, error_d;
  logic                      done_prev_q, done_prev_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_ena_d    = rd_ena_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = '0;
    buf_d       = buf_q;
    sclk_d      = 1'b0;
    sclkena_d   = 1'b0;
    sdata_d     = sdata_q;
    upd_d       = 1'b0;
    areset_d    = 1'b0;
    error_d     = error_q;
    done_prev_d = pll_scandone;
    // read-enable delayed by ROM_LATENCY marks the clock rom_q is valid
    vld_d       = ROM_LATENCY'({vld_q, rd_ena_q});

    case (state_q)
      S_IDLE: begin
        if (trigger_read) begin
          state_d   = S_LOAD;
          addr_d    = 8'd0;
          rd_ena_d  = 1'b1;
          bit_cnt_d = 9'd0;
          error_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (rd_ena_q) begin
          if (addr_q == LAST_ADDR) rd_ena_d = 1'b0;
          else                     addr_d   = addr_q + 8'd1;
        end
        // bits arrive in address order, so shifting in from the top leaves bit k at buf_q[k]
        if (vld_q[ROM_LATENCY-1]) begin
          buf_d = {rom_q, buf_q[SCAN_CHAIN_LEN-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = S_WAIT_RECONF;
            bit_cnt_d = 9'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 9'd1;
          end
        end
      end
      S_WAIT_RECONF: begin
        tmo_d = tmo_q + TW'(1);
        if (rom_reconfig) begin
          state_d   = S_SHIFT;
          sclkena_d = 1'b1;
          sdata_d   = buf_q[0];
          buf_d     = {buf_q[0], buf_q[SCAN_CHAIN_LEN-1:1]};
          bit_cnt_d = 9'd0;
        end else if (tmo_d == TMO_LIMIT) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end
      end
      S_SHIFT: begin
        sclkena_d = 1'b1;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bit_cnt_q == LAST_BIT) begin
          state_d   = S_UPDATE;
          sclkena_d = 1'b0;
          sdata_d   = 1'b0;
          upd_d     = 1'b1;
        end else begin
          sdata_d   = buf_q[0];
          buf_d     = {buf_q[0], buf_q[SCAN_CHAIN_LEN-1:1]};
          bit_cnt_d = bit_cnt_q + 9'd1;
        end
      end
      S_UPDATE: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        tmo_d = tmo_q + TW'(1);
        if (pll_scandone && !done_prev_q) begin
          state_d  = S_PLL_RST;
          areset_d = 1'b1;
        end else if (tmo_d == TMO_LIMIT) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end
      end
      S_PLL_RST: begin
        tmo_d    = tmo_q + TW'(1);
        areset_d = 1'b1;
        if (tmo_q == RST_LAST) begin
          state_d  = S_IDLE;
          areset_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) tmo_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rd_ena_q    <= 1'b0;
      vld_q       <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      buf_q       <= '0;
      sclk_q      <= 1'b0;
      sclkena_q   <= 1'b0;
      sdata_q     <= 1'b0;
      upd_q       <= 1'b0;
      areset_q    <= 1'b0;
      error_q     <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_ena_q    <= rd_ena_d;
      vld_q       <= vld_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      buf_q       <= buf_d;
      sclk_q      <= sclk_d;
      sclkena_q   <= sclkena_d;
      sdata_q     <= sdata_d;
      upd_q       <= upd_d;
      areset_q    <= areset_d;
      error_q     <= error_d;
      done_prev_q <= done_prev_d;
    end
  end

  assign rom_address      = addr_q;
  assign rom_read_ena     = rd_ena_q;
  assign pll_scanclk      = sclk_q;
  assign pll_scanclkena   = sclkena_q;
  assign pll_scandata     = sdata_q;
  assign pll_configupdate = upd_q;
  assign pll_areset       = areset_q;
  assign busy             = (state_q != S_IDLE);
  assign error            = error_q;

endmodule

// File: tb/tb_pll_scan_reconfig_ctrl.sv
// Bench for pll_scan_reconfig_ctrl: full-size and 8-bit/latency-1 instances
// driven by behavioural ROM and PLL models, checked per transaction.
module tb_pll_scan_reconfig_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic trig = 1'b0, rom_q = 1'b0, rom_reconfig = 1'b0, pll_scandone = 1'b0;
  logic sel = 1'b0;
  logic trig1, trig2;

  logic [7:0] a1, a2;
  logic e1, e2, c1, c2, ce1, ce2, d1, d2, u1, u2, r1, r2, b1, b2, er1, er2;

  logic [7:0] m_addr;
  logic m_ena, m_sclk, m_sclkena, m_sdata, m_upd, m_ares, m_busy, m_err;

  int n_cmp = 0;
  int n_mis = 0;
  int cur_vec = -1;
  logic pat [0:255];

  always #5 clock = ~clock;

  assign trig1 = trig & ~sel;
  assign trig2 = trig & sel;

  pll_scan_reconfig_ctrl dut_big (
    .clock(clock), .reset(reset), .trigger_read(trig1),
    .rom_address(a1), .rom_read_ena(e1), .rom_q(rom_q), .rom_reconfig(rom_reconfig),
    .pll_scanclk(c1), .pll_scanclkena(ce1), .pll_scandata(d1), .pll_configupdate(u1),
    .pll_scandone(pll_scandone), .pll_areset(r1), .busy(b1), .error(er1)
  );

  pll_scan_reconfig_ctrl #(.SCAN_CHAIN_LEN(8), .ROM_LATENCY(1)) dut_small (
    .clock(clock), .reset(reset), .trigger_read(trig2),
    .rom_address(a2), .rom_read_ena(e2), .rom_q(rom_q), .rom_reconfig(rom_reconfig),
    .pll_scanclk(c2), .pll_scanclkena(ce2), .pll_scandata(d2), .pll_configupdate(u2),
    .pll_scandone(pll_scandone), .pll_areset(r2), .busy(b2), .error(er2)
  );

  assign m_addr    = sel ? a2  : a1;
  assign m_ena     = sel ? e2  : e1;
  assign m_sclk    = sel ? c2  : c1;
  assign m_sclkena = sel ? ce2 : ce1;
  assign m_sdata   = sel ? d2  : d1;
  assign m_upd     = sel ? u2  : u1;
  assign m_ares    = sel ? r2  : r1;
  assign m_busy    = sel ? b2  : b1;
  assign m_err     = sel ? er2 : er1;

  typedef struct {
    logic sel;
    logic rand_pat;
    logic give_reconf;
    logic give_done;
    logic dbl;
    int   rst_at;
    int   exp_addrs;
    int   exp_edges;
    int   exp_upd;
    int   exp_ares;
    logic exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL v%0d %s: got %0d, expected %0d", cur_vec, name, act, exp);
    end
  endtask

  function automatic int outs1();
    return int'({a1, e1, c1, ce1, d1, u1, r1, b1, er1});
  endfunction

  function automatic int outs2();
    return int'({a2, e2, c2, ce2, d2, u2, r2, b2, er2});
  endfunction

  task automatic run_vec(input vec_t v);
    int n_len, lat, cyc, fall_cyc, upd_cyc, err_cyc, dly;
    int bad_addr, bad_bits, bad_stab, bad_ena, upd_clk_bad, n_upd, n_ares, idle_bad;
    int addrs[$];
    int qa[$];
    logic bits[$];
    logic prev_clk, prev_dat, prev_ena, prev_err, injected, done;
    logic [7:0] kb;

    n_len = v.sel ? 8 : 144;
    lat   = v.sel ? 1 : 2;
    sel   = v.sel;
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      pat[k] = v.rand_pat ? 1'($urandom_range(0, 1)) : (kb[0] ^ kb[3]);
    end
    dly = $urandom_range(1, 12);
    cyc = 0; fall_cyc = -1; upd_cyc = -1; err_cyc = -1;
    bad_addr = 0; bad_bits = 0; bad_stab = 0; bad_ena = 0; upd_clk_bad = 0;
    n_upd = 0; n_ares = 0; idle_bad = 0;
    injected = 1'b0; done = 1'b0;

    @(negedge clock);
    prev_clk = m_sclk; prev_dat = m_sdata; prev_ena = m_ena; prev_err = m_err;
    trig = 1'b1;

    while (!done && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        chk("busy_after_trigger", int'(m_busy), 1);
        chk("error_cleared_by_trigger", int'(m_err), 0);
      end
      if (m_ena) addrs.push_back(int'(m_addr));
      if (prev_ena && !m_ena && fall_cyc < 0) fall_cyc = cyc;
      if (m_sclk && !m_sclkena) bad_ena++;
      if (m_sclk && !prev_clk) begin
        bits.push_back(m_sdata);
        if (m_sdata != prev_dat) bad_stab++;
      end
      if (m_upd) begin
        n_upd++;
        upd_cyc = cyc;
        if (m_sclk || m_sclkena) upd_clk_bad++;
      end
      if (m_ares) n_ares++;
      if (m_err && !prev_err) err_cyc = cyc;
      if (!m_busy) done = 1'b1;
      prev_clk = m_sclk; prev_dat = m_sdata; prev_ena = m_ena; prev_err = m_err;

      if (v.rst_at > 0 && bits.size() == v.rst_at) begin
        reset = 1'b1;
        #1;
        chk("outputs_zero_during_reset", outs1(), 0);
        trig = 1'b0; rom_reconfig = 1'b0; pll_scandone = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("busy_after_reset_release", int'(m_busy), 0);
        return;
      end

      trig = 1'b0;
      if (v.dbl && !injected && bits.size() == n_len / 2) begin
        trig = 1'b1;
        injected = 1'b1;
      end
      qa.push_back(int'(m_addr));
      if (qa.size() > lat) rom_q = pat[qa.pop_front()];
      rom_reconfig = v.give_reconf && fall_cyc >= 0 && cyc == fall_cyc + 3;
      if (m_ares) pll_scandone = 1'b0;
      else if (v.give_done && upd_cyc >= 0 && cyc == upd_cyc + dly) pll_scandone = 1'b1;
    end
    trig = 1'b0; rom_reconfig = 1'b0;

    chk("txn_done_within_budget", int'(done), 1);
    repeat (8) begin
      @(negedge clock);
      if (m_busy || m_ena || m_sclk) idle_bad++;
    end
    chk("stays_idle_after_txn", idle_bad, 0);

    chk("rom_address_count", addrs.size(), v.exp_addrs);
    foreach (addrs[i]) if (addrs[i] != i) bad_addr++;
    chk("rom_address_sequence_errors", bad_addr, 0);
    chk("scanclk_rising_edges", bits.size(), v.exp_edges);
    foreach (bits[i]) if (i < n_len && bits[i] != pat[i]) bad_bits++;
    chk("scandata_bit_errors", bad_bits, 0);
    chk("scandata_unstable_at_rise", bad_stab, 0);
    chk("scanclk_without_ena", bad_ena, 0);
    chk("configupdate_pulses", n_upd, v.exp_upd);
    chk("scanclk_active_at_update", upd_clk_bad, 0);
    chk("areset_cycles", n_ares, v.exp_ares);
    chk("error_flag", int'(m_err), int'(v.exp_err));
    if (!v.give_reconf)
      chk("reconf_timeout_latency", err_cyc - fall_cyc, lat + 1024);
    else if (!v.give_done)
      chk("scandone_timeout_latency", err_cyc - upd_cyc, 1025);
  endtask

  initial begin
    //          sel   rand  rcfg  done  dbl   rst  addrs edges upd ares err
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0,   144,  144,  1,  4,   1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20,  144,  144,  1,  4,   1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0,   144,  144,  1,  4,   1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0,   144,  0,    0,  0,   1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0,   144,  144,  1,  0,   1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0,   144,  144,  1,  4,   1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0,   8,    8,    1,  4,   1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0,   8,    8,    1,  4,   1'b0};

    repeat (3) @(negedge clock);
    chk("reset_outputs_big", outs1(), 0);
    chk("reset_outputs_small", outs2(), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_without_trigger", int'(b1 | b2 | e1 | e2), 0);

    for (int i = 0; i < 8; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
